// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Purpose: parametrised VGA raster timing (counters, sync, blank, coordinates, strobes) and RGB332 pixel output.
// Latency: PixelX/PixelY combinational from counters; sync/blank/RGB appear 1+PIPE_DELAY pixel ticks later.
// Backpressure: none; free-running raster, all state advances only on the pixel-tick enable.
module vga_timing_gen #(
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_ACT      = 640,
    parameter int V_FRONT    = 11,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 31,
    parameter int V_ACT      = 480,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CLK_DIV    = 1,
    parameter int PIPE_DELAY = 0,
    parameter int FRAME_W    = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [7:0]         RGBIn,
    output logic [10:0]        PixelX,
    output logic [10:0]        PixelY,
    output logic               pixTick,
    output logic               startOfLine,
    output logic               startOfFrame,
    output logic [FRAME_W-1:0] frameCount,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACT;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACT;
    localparam int CW      = 12;

    logic [3:0]           div_cnt;
    logic                 run_q;
    logic [CW-1:0]        h_cnt;
    logic [CW-1:0]        v_cnt;
    logic                 h_last;
    logic                 v_last;
    logic                 h_act;
    logic                 v_act;
    logic                 hs_lvl;
    logic                 vs_lvl;
    logic [PIPE_DELAY:0]  hs_pipe;
    logic [PIPE_DELAY:0]  vs_pipe;
    logic [PIPE_DELAY:0]  act_pipe;
    logic [7:0]           rgb_q;

    assign h_last = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt == CW'(V_TOTAL - 1));

    // run_q keeps pixTick low while in reset even when CLK_DIV=1 makes the divider match immediately
    assign pixTick = run_q && (div_cnt == 4'(CLK_DIV - 1));

    // Pixel clock-enable divider, counts 0..CLK_DIV-1
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_cnt <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            div_cnt <= (div_cnt == 4'(CLK_DIV - 1)) ? 4'd0 : div_cnt + 4'd1;
        end
    end

    // Horizontal and vertical raster counters, advancing on pixel ticks
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixTick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Line/frame strobes land in the same cycle the counters wrap to 0; frame counter moves with them
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            startOfLine  <= 1'b0;
            startOfFrame <= 1'b0;
            frameCount   <= '0;
        end else begin
            startOfLine  <= pixTick && h_last;
            startOfFrame <= pixTick && h_last && v_last;
            if (pixTick && h_last && v_last)
                frameCount <= frameCount + 1'b1;
        end
    end

    // Raster decode: porch/sync/porch/active ordering within each line and frame
    always_comb begin
        h_act  = (h_cnt >= CW'(H_BLANK));
        v_act  = (v_cnt >= CW'(V_BLANK));
        hs_lvl = ((h_cnt >= CW'(H_FRONT)) && (h_cnt < CW'(H_FRONT + H_SYNC))) ? HS_POL : ~HS_POL;
        vs_lvl = ((v_cnt >= CW'(V_FRONT)) && (v_cnt < CW'(V_FRONT + V_SYNC))) ? VS_POL : ~VS_POL;
        PixelX = h_act ? 11'(h_cnt - CW'(H_BLANK)) : 11'd0;
        PixelY = v_act ? 11'(v_cnt - CW'(V_BLANK)) : 11'd0;
    end

    // Sync/blank delay line plus RGB capture, so outputs line up with the drawing logic's latency
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hs_pipe  <= {(PIPE_DELAY + 1){~HS_POL}};
            vs_pipe  <= {(PIPE_DELAY + 1){~VS_POL}};
            act_pipe <= '0;
            rgb_q    <= '0;
        end else if (pixTick) begin
            hs_pipe[0]  <= hs_lvl;
            vs_pipe[0]  <= vs_lvl;
            act_pipe[0] <= h_act && v_act;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                act_pipe[i] <= act_pipe[i-1];
            end
            rgb_q <= RGBIn;
        end
    end

    assign vga_hs      = hs_pipe[PIPE_DELAY];
    assign vga_vs      = vs_pipe[PIPE_DELAY];
    assign vga_blank_n = act_pipe[PIPE_DELAY];

    // RGB332 expansion by bit replication, blanked outside the active area
    always_comb begin
        vga_r = '0;
        vga_g = '0;
        vga_b = '0;
        if (vga_blank_n) begin
            vga_r = {rgb_q[7:5], rgb_q[7:5], rgb_q[7:6]};
            vga_g = {rgb_q[4:2], rgb_q[4:2], rgb_q[4:3]};
            vga_b = {rgb_q[1:0], rgb_q[1:0], rgb_q[1:0], rgb_q[1:0]};
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen using a tiny 12x6 raster (H: 2/3/1/6, V: 1/1/1/3).
// Instance a: CLK_DIV=1, PIPE_DELAY=0, active-low syncs, 2-bit frame counter.
// Instance b: CLK_DIV=4, PIPE_DELAY=3, active-high syncs.
module tb_vga_timing_gen;

    logic        clk;
    logic        resetN;
    logic [7:0]  RGBIn;

    logic [10:0] a_PixelX, a_PixelY, b_PixelX, b_PixelY;
    logic        a_pixTick, a_sol, a_sof, b_pixTick, b_sol, b_sof;
    logic [1:0]  a_fc;
    logic [15:0] b_fc;
    logic        a_hs, a_vs, a_bn, b_hs, b_vs, b_bn;
    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;

    int checks = 0;
    int errors = 0;
    int kc     = 0;

    vga_timing_gen #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .H_ACT(6),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(3),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .PIPE_DELAY(0), .FRAME_W(2)
    ) u_a (
        .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
        .PixelX(a_PixelX), .PixelY(a_PixelY), .pixTick(a_pixTick),
        .startOfLine(a_sol), .startOfFrame(a_sof), .frameCount(a_fc),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_blank_n(a_bn),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
    );

    vga_timing_gen #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .H_ACT(6),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(4), .PIPE_DELAY(3), .FRAME_W(16)
    ) u_b (
        .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
        .PixelX(b_PixelX), .PixelY(b_PixelY), .pixTick(b_pixTick),
        .startOfLine(b_sol), .startOfFrame(b_sof), .frameCount(b_fc),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_bn),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kc = number of rising edges since reset release; samples are taken 1ns after each edge
    task automatic step_to(input int t);
        while (kc < t) begin
            @(posedge clk);
            #1;
            kc++;
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        resetN = 1'b1;
        kc     = 0;
    endtask

    initial begin : stim
        int bn_cnt;
        int sof_cnt;
        int sof_at;
        int sol_wait;

        RGBIn  = 8'h00;
        resetN = 1'b1;
        #2;
        do_reset();

        // ---------------- reset values ----------------
        check("rst_a_pixTick", a_pixTick, 0);
        check("rst_a_sol",     a_sol, 0);
        check("rst_a_sof",     a_sof, 0);
        check("rst_a_fc",      a_fc, 0);
        check("rst_a_hs",      a_hs, 1);
        check("rst_a_vs",      a_vs, 1);
        check("rst_a_blank",   a_bn, 0);
        check("rst_a_rgb",     {a_r, a_g, a_b}, 0);
        check("rst_b_hs",      b_hs, 0);
        check("rst_b_vs",      b_vs, 0);
        check("rst_b_pixTick", b_pixTick, 0);

        release_reset();

        // ---------------- instance a: CLK_DIV=1, PIPE_DELAY=0 ----------------
        step_to(1);
        check("a_tick_every_clk", a_pixTick, 1);
        check("a_px_h0", a_PixelX, 0);
        step_to(12);                                // h=11, v=0
        check("a_px_h11", a_PixelX, 5);
        check("a_py_vblank", a_PixelY, 0);
        check("a_sol_before", a_sol, 0);
        step_to(13);                                // h=0, v=1
        check("a_sol_pulse", a_sol, 1);
        check("a_sof_not_line", a_sof, 0);
        check("a_vs_prewrap", a_vs, 1);
        step_to(14);                                // h=1, v=1
        check("a_sol_width", a_sol, 0);
        check("a_vs_low", a_vs, 0);
        check("a_hs_idle", a_hs, 1);
        step_to(15);                                // h=2
        check("a_hs_h2", a_hs, 1);
        step_to(16);                                // h=3
        check("a_hs_fall", a_hs, 0);
        step_to(18);                                // h=5
        check("a_hs_h5", a_hs, 0);
        check("a_px_h5", a_PixelX, 0);
        step_to(19);                                // h=6
        check("a_hs_rise", a_hs, 1);
        check("a_blank_vblank", a_bn, 0);

        RGBIn = 8'hFF;
        step_to(43);                                // h=6, v=3: first active pixel
        check("a_px_first", a_PixelX, 0);
        check("a_py_first", a_PixelY, 0);
        check("a_blank_lag", a_bn, 0);
        check("a_rgb_blanked", a_r, 0);
        step_to(44);
        check("a_blank_on", a_bn, 1);
        check("a_rgb_ff", {a_r, a_g, a_b}, 24'hFFFFFF);
        RGBIn = 8'h49;
        step_to(45);
        check("a_r_49", a_r, 8'h49);
        check("a_g_49", a_g, 8'h49);
        check("a_b_55", a_b, 8'h55);
        step_to(49);                                // h=0, v=4
        check("a_py_row1", a_PixelY, 1);
        check("a_px_hblank", a_PixelX, 0);
        check("a_blank_tail", a_bn, 1);
        step_to(50);                                // h=1, v=4
        check("a_blank_off", a_bn, 0);
        check("a_rgb_off", {a_r, a_g, a_b}, 0);
        step_to(72);                                // h=11, v=5
        check("a_py_last", a_PixelY, 2);
        check("a_px_last", a_PixelX, 5);
        check("a_fc_0", a_fc, 0);
        step_to(73);                                // h=0, v=0
        check("a_sof_pulse", a_sof, 1);
        check("a_sol_at_sof", a_sol, 1);
        check("a_fc_1", a_fc, 1);

        bn_cnt  = 0;
        sof_cnt = 0;
        sof_at  = 0;
        for (int i = 1; i <= 72; i++) begin
            step_to(73 + i);
            if (a_bn) bn_cnt++;
            if (a_sof) begin
                sof_cnt++;
                sof_at = i;
            end
        end
        check("a_blank_per_frame", bn_cnt, 18);
        check("a_sof_count", sof_cnt, 1);
        check("a_sof_period", sof_at, 72);
        check("a_fc_2", a_fc, 2);
        step_to(146);
        check("a_sof_width", a_sof, 0);
        step_to(217);
        check("a_fc_3", a_fc, 3);
        step_to(289);
        check("a_fc_wrap", a_fc, 0);
        check("a_sof_wrap", a_sof, 1);

        // ---------------- mid-line asynchronous reset ----------------
        step_to(297);                               // h=8, v=0
        check("a_px_vblank_own", a_PixelX, 2);
        #2;
        resetN = 1'b0;
        #1;
        check("mr_a_px", a_PixelX, 0);
        check("mr_a_tick", a_pixTick, 0);
        check("mr_a_hs", a_hs, 1);
        check("mr_a_fc", a_fc, 0);
        check("mr_b_hs", b_hs, 0);
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        sol_wait = 0;
        while (a_sol !== 1'b1 && kc < 40) begin
            step_to(kc + 1);
            if (a_sol === 1'b1) sol_wait = kc;
        end
        check("mr_first_sol", sol_wait, 13);

        // ---------------- instance b: CLK_DIV=4, PIPE_DELAY=3, active-high syncs ----------------
        do_reset();
        RGBIn = 8'hFF;
        release_reset();
        step_to(3);
        check("b_tick_k3", b_pixTick, 1);
        step_to(4);
        check("b_tick_k4", b_pixTick, 0);
        step_to(7);
        check("b_tick_k7", b_pixTick, 1);
        step_to(23);
        check("b_hs_before", b_hs, 0);
        step_to(24);
        check("b_hs_rise", b_hs, 1);
        check("b_px_h6", b_PixelX, 0);
        step_to(27);
        check("b_px_hold", b_PixelX, 0);
        step_to(28);
        check("b_px_h7", b_PixelX, 1);
        step_to(35);
        check("b_hs_high", b_hs, 1);
        step_to(36);
        check("b_hs_fall", b_hs, 0);
        step_to(47);
        check("b_sol_pre", b_sol, 0);
        step_to(48);
        check("b_sol_pulse", b_sol, 1);
        step_to(49);
        check("b_sol_width", b_sol, 0);
        step_to(63);
        check("b_vs_before", b_vs, 0);
        step_to(64);
        check("b_vs_rise", b_vs, 1);
        step_to(95);
        check("b_sol_gap", b_sol, 0);
        step_to(96);
        check("b_sol_period", b_sol, 1);
        step_to(183);
        check("b_blank_before", b_bn, 0);
        step_to(184);
        check("b_blank_rise", b_bn, 1);
        check("b_rgb_ff", {b_r, b_g, b_b}, 24'hFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
